// File: rtl/fsmc_fifo_regs_pkg.sv
// Shared constants for the FSMC sample FIFO peripheral: register indices,
// status/control bit positions and the default word width.
package fsmc_pkg;

    localparam int FSMC_DATA_W = 16;

    typedef enum logic [2:0] {
        REG_DATA    = 3'd0,
        REG_STATUS  = 3'd1,
        REG_COUNT   = 3'd2,
        REG_THRESH  = 3'd3,
        REG_OVF_CNT = 3'd4
    } reg_idx_e;

    localparam int ST_EMPTY  = 0;
    localparam int ST_FULL   = 1;
    localparam int ST_OVF    = 2;
    localparam int ST_IRQ    = 3;
    localparam int CTL_FLUSH = 15;

endpackage

// File: rtl/fsmc_fifo_regs_if.sv
// Register-strobe bus from the FSMC slave plus the fabric push port.
// The master side is the bus slave / fabric source, the slave side is the FIFO block.
interface fsmc_fifo_regs_if
    import fsmc_pkg::*;
#(
    parameter int DATA_W = FSMC_DATA_W
) ();

    logic              cs;
    logic [2:0]        reg_addr;
    logic              wr_stb;
    logic              rd_stb;
    logic [DATA_W-1:0] wdata;
    logic [DATA_W-1:0] rdata;
    logic              src_valid;
    logic [DATA_W-1:0] src_data;
    logic              src_ready;

    modport master (
        output cs, reg_addr, wr_stb, rd_stb, wdata, src_valid, src_data,
        input  rdata, src_ready
    );

    modport slave (
        input  cs, reg_addr, wr_stb, rd_stb, wdata, src_valid, src_data,
        output rdata, src_ready
    );

endinterface

// File: rtl/fsmc_fifo_regs_fifo_sync_mem.sv
// Single-clock FIFO storage: array, wrapping pointers, occupancy count.
// Flush overrides push and pop; head is the combinational word at the read pointer.
module fifo_sync_mem #(
    parameter int DATA_W = 16,
    parameter int DEPTH  = 16
) (
    input  logic                     clk,
    input  logic                     reset_n,
    input  logic                     push,
    input  logic                     pop,
    input  logic                     flush,
    input  logic [DATA_W-1:0]        push_data,
    output logic [DATA_W-1:0]        head,
    output logic [$clog2(DEPTH):0]   count,
    output logic [$clog2(DEPTH):0]   count_next,
    output logic                     full,
    output logic                     empty
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    typedef logic [PW-1:0] ptr_t;
    typedef logic [CW-1:0] cnt_t;

    localparam cnt_t DEPTH_C = cnt_t'(DEPTH);

    logic [DATA_W-1:0] mem_q [DEPTH];
    ptr_t              wr_ptr_q, wr_ptr_d;
    ptr_t              rd_ptr_q, rd_ptr_d;
    cnt_t              count_q, count_d;
    logic              push_en, pop_en;

    assign full  = (count_q == DEPTH_C);
    assign empty = (count_q == '0);

    // Acceptance is judged on the registered full/empty, so a same-cycle pop never frees a slot.
    assign push_en = push && !full && !flush;
    assign pop_en  = pop && !empty && !flush;

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (flush) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (push_en) begin
                wr_ptr_d = wr_ptr_q + ptr_t'(1);
            end
            if (pop_en) begin
                rd_ptr_d = rd_ptr_q + ptr_t'(1);
            end
            case ({push_en, pop_en})
                2'b10:   count_d = count_q + cnt_t'(1);
                2'b01:   count_d = count_q - cnt_t'(1);
                default: count_d = count_q;
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    always_ff @(posedge clk) begin
        if (push_en) begin
            mem_q[wr_ptr_q] <= push_data;
        end
    end

    assign head       = mem_q[rd_ptr_q];
    assign count      = count_q;
    assign count_next = count_d;

endmodule

// File: rtl/fsmc_fifo_regs.sv
// Memory-mapped sample FIFO behind the FSMC bus slave: register decode, sticky overflow,
// threshold interrupt and registered read data. Define FIFO_OVF_COUNT_EN to add OVF_CNT.
module fsmc_fifo_regs
    import fsmc_pkg::*;
#(
    parameter int DATA_W     = FSMC_DATA_W,
    parameter int DEPTH      = 16,
    parameter int THRESH_RST = 8
) (
    input  logic                   clk,
    input  logic                   reset_n,
    fsmc_fifo_regs_if.slave        bus,
    output logic                   irq
);

    localparam int CW = $clog2(DEPTH) + 1;

    typedef logic [CW-1:0] cnt_t;

    logic              wr_en, rd_en;
    logic              flush, push_req, pop_req, drop;
    logic              full, empty;
    logic [DATA_W-1:0] head;
    cnt_t              fifo_count, fifo_count_next;

    cnt_t              thresh_q, thresh_d;
    logic              ovf_q, ovf_d;
    logic              irq_q, irq_d;
    logic [DATA_W-1:0] rdata_q, rdata_d;
    logic [DATA_W-1:0] status_rd, count_rd, thresh_rd, ovf_cnt_rd;
    logic              wdata_unused;

    assign wr_en = bus.cs && bus.wr_stb;
    assign rd_en = bus.cs && bus.rd_stb;

    assign flush    = wr_en && (bus.reg_addr == REG_STATUS) && bus.wdata[CTL_FLUSH];
    assign push_req = bus.src_valid;
    assign pop_req  = rd_en && (bus.reg_addr == REG_DATA);
    // A flush swallows a colliding push silently, so it must not count as an overflow.
    assign drop     = bus.src_valid && full && !flush;

    assign wdata_unused = ^bus.wdata;

    fifo_sync_mem #(
        .DATA_W (DATA_W),
        .DEPTH  (DEPTH)
    ) u_fifo (
        .clk        (clk),
        .reset_n    (reset_n),
        .push       (push_req),
        .pop        (pop_req),
        .flush      (flush),
        .push_data  (bus.src_data),
        .head       (head),
        .count      (fifo_count),
        .count_next (fifo_count_next),
        .full       (full),
        .empty      (empty)
    );

    assign bus.src_ready = !full;

    always_comb begin
        ovf_d = ovf_q;
        if (wr_en && (bus.reg_addr == REG_STATUS) && bus.wdata[ST_OVF]) begin
            ovf_d = 1'b0;
        end
        if (drop) begin
            ovf_d = 1'b1;
        end
    end

    always_comb begin
        thresh_d = thresh_q;
        if (wr_en && (bus.reg_addr == REG_THRESH)) begin
            thresh_d = bus.wdata[CW-1:0];
        end
    end

    // THRESH wider than DEPTH can never be reached by count, so it never fires.
    assign irq_d = (thresh_d != '0) && (fifo_count_next >= thresh_d);

`ifdef FIFO_OVF_COUNT_EN
    logic [15:0] ovf_cnt_q, ovf_cnt_d;

    always_comb begin
        ovf_cnt_d = ovf_cnt_q;
        if (wr_en && (bus.reg_addr == REG_OVF_CNT)) begin
            ovf_cnt_d = '0;
        end else if (drop && (ovf_cnt_q != 16'hFFFF)) begin
            ovf_cnt_d = ovf_cnt_q + 16'd1;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            ovf_cnt_q <= '0;
        end else begin
            ovf_cnt_q <= ovf_cnt_d;
        end
    end

    always_comb begin
        ovf_cnt_rd        = '0;
        ovf_cnt_rd[15:0]  = ovf_cnt_q;
    end
`else
    assign ovf_cnt_rd = '0;
`endif

    always_comb begin
        status_rd           = '0;
        status_rd[ST_EMPTY] = empty;
        status_rd[ST_FULL]  = full;
        status_rd[ST_OVF]   = ovf_q;
        status_rd[ST_IRQ]   = irq_q;
        count_rd            = '0;
        count_rd[CW-1:0]    = fifo_count;
        thresh_rd           = '0;
        thresh_rd[CW-1:0]   = thresh_q;
    end

    // Read data holds between strobes so the bus slave can sample it late in the cycle.
    always_comb begin
        rdata_d = rdata_q;
        if (rd_en) begin
            case (bus.reg_addr)
                REG_DATA:    rdata_d = empty ? '0 : head;
                REG_STATUS:  rdata_d = status_rd;
                REG_COUNT:   rdata_d = count_rd;
                REG_THRESH:  rdata_d = thresh_rd;
                REG_OVF_CNT: rdata_d = ovf_cnt_rd;
                default:     rdata_d = '0;
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            thresh_q <= cnt_t'(THRESH_RST);
            ovf_q    <= 1'b0;
            irq_q    <= 1'b0;
            rdata_q  <= '0;
        end else begin
            thresh_q <= thresh_d;
            ovf_q    <= ovf_d;
            irq_q    <= irq_d;
            rdata_q  <= rdata_d;
        end
    end

    assign bus.rdata = rdata_q;
    assign irq       = irq_q;

endmodule

// File: tb/tb_fsmc_fifo_regs.sv
// Scoreboard bench for fsmc_fifo_regs: pushed words are queued and popped on DATA reads;
// a small model tracks count, ovf, THRESH and OVF_CNT to predict register reads.
module tb_fsmc_fifo_regs;

    localparam int DEPTH = 16;

    logic clk;
    logic reset_n;
    logic irq;

    fsmc_fifo_regs_if #(.DATA_W(16)) bus_if ();

    fsmc_fifo_regs #(
        .DATA_W     (16),
        .DEPTH      (DEPTH),
        .THRESH_RST (8)
    ) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus_if),
        .irq     (irq)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int          total = 0;
    int          bad   = 0;
    logic [15:0] sb[$];
    int          mCount;
    bit          mOvf;
    int          mThresh;
    int          mOvfCnt;

    function automatic bit expIrq();
        return (mThresh != 0) && (mCount >= mThresh);
    endfunction

    function automatic logic [15:0] expStatus();
        logic [15:0] s;
        s    = '0;
        s[0] = (mCount == 0);
        s[1] = (mCount == DEPTH);
        s[2] = mOvf;
        s[3] = expIrq();
        return s;
    endfunction

    function automatic logic [15:0] expOvfCnt();
`ifdef FIFO_OVF_COUNT_EN
        return 16'(mOvfCnt);
`else
        return 16'h0000;
`endif
    endfunction

    task automatic modelReset();
        sb.delete();
        mCount  = 0;
        mOvf    = 1'b0;
        mThresh = 8;
        mOvfCnt = 0;
    endtask

    task automatic modelPush(input logic [15:0] d);
        if (mCount < DEPTH) begin
            sb.push_back(d);
            mCount++;
        end else begin
            mOvf = 1'b1;
            if (mOvfCnt < 65535) mOvfCnt++;
        end
    endtask

    task automatic modelPop(output logic [15:0] expd);
        if (sb.size() > 0) begin
            expd = sb.pop_front();
            mCount--;
        end else begin
            expd = 16'h0000;
        end
    endtask

    task automatic cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic bus_write(input logic [2:0] a, input logic [15:0] d);
        bus_if.cs = 1'b1; bus_if.wr_stb = 1'b1; bus_if.reg_addr = a; bus_if.wdata = d;
        cycle();
        bus_if.cs = 1'b0; bus_if.wr_stb = 1'b0;
        if (a == 3'd1) begin
            if (d[2]) mOvf = 1'b0;
            if (d[15]) begin sb.delete(); mCount = 0; end
        end else if (a == 3'd3) begin
            mThresh = int'(d[4:0]);
        end else if (a == 3'd4) begin
            mOvfCnt = 0;
        end
    endtask

    task automatic bus_read(input logic [2:0] a, output logic [15:0] d);
        bus_if.cs = 1'b1; bus_if.rd_stb = 1'b1; bus_if.reg_addr = a;
        cycle();
        bus_if.cs = 1'b0; bus_if.rd_stb = 1'b0;
        d = bus_if.rdata;
    endtask

    task automatic push_word(input logic [15:0] d);
        bus_if.src_valid = 1'b1; bus_if.src_data = d;
        modelPush(d);
        cycle();
        bus_if.src_valid = 1'b0;
    endtask

    task automatic test_reset();
        logic [15:0] got;
        reset_n = 1'b0;
        bus_if.cs = 0; bus_if.wr_stb = 0; bus_if.rd_stb = 0; bus_if.reg_addr = 0;
        bus_if.wdata = 0; bus_if.src_valid = 0; bus_if.src_data = 0;
        modelReset();
        repeat (3) cycle();
        total++;
        if (bus_if.rdata !== 16'h0000) begin bad++; $display("[TB] FAIL rdata_in_reset: got %h want 0000", bus_if.rdata); end
        total++;
        if (irq !== 1'b0) begin bad++; $display("[TB] FAIL irq_in_reset: got %b want 0", irq); end
        total++;
        if (bus_if.src_ready !== 1'b1) begin bad++; $display("[TB] FAIL src_ready_in_reset: got %b want 1", bus_if.src_ready); end
        reset_n = 1'b1;
        cycle();
        bus_read(3'd1, got);
        total++;
        if (got !== 16'h0001) begin bad++; $display("[TB] FAIL status_after_reset: got %h want 0001", got); end
        bus_read(3'd2, got);
        total++;
        if (got !== 16'h0000) begin bad++; $display("[TB] FAIL count_after_reset: got %h want 0000", got); end
        bus_read(3'd3, got);
        total++;
        if (got !== 16'h0008) begin bad++; $display("[TB] FAIL thresh_after_reset: got %h want 0008", got); end
    endtask

    task automatic test_fifo_order();
        logic [15:0] got, expd;
        push_word(16'h0F0F);
        push_word(16'h1234);
        push_word(16'hBEEF);
        for (int i = 0; i < 4; i++) begin
            modelPop(expd);
            bus_read(3'd0, got);
            total++;
            if (got !== expd) begin bad++; $display("[TB] FAIL data_read_%0d: got %h want %h", i, got, expd); end
            if (i == 2) begin
                cycle();
                total++;
                if (bus_if.rdata !== expd) begin bad++; $display("[TB] FAIL rdata_hold: got %h want %h", bus_if.rdata, expd); end
            end
        end
        bus_read(3'd2, got);
        total++;
        if (got !== 16'(mCount)) begin bad++; $display("[TB] FAIL count_after_empty_read: got %h want %h", got, 16'(mCount)); end
    endtask

    task automatic test_full_ovf();
        logic [15:0] got;
        bus_write(3'd3, 16'h0000);
        for (int i = 0; i < DEPTH; i++) push_word(16'h1000 + 16'(i));
        total++;
        if (bus_if.src_ready !== (mCount < DEPTH)) begin bad++; $display("[TB] FAIL src_ready_full: got %b want %b", bus_if.src_ready, mCount < DEPTH); end
        bus_read(3'd1, got);
        total++;
        if (got !== expStatus()) begin bad++; $display("[TB] FAIL status_full: got %h want %h", got, expStatus()); end
        push_word(16'hDEAD);
        bus_read(3'd1, got);
        total++;
        if (got !== expStatus()) begin bad++; $display("[TB] FAIL status_ovf: got %h want %h", got, expStatus()); end
        bus_read(3'd4, got);
        total++;
        if (got !== expOvfCnt()) begin bad++; $display("[TB] FAIL ovf_cnt: got %h want %h", got, expOvfCnt()); end
        bus_write(3'd1, 16'h0004);
        bus_read(3'd1, got);
        total++;
        if (got !== expStatus()) begin bad++; $display("[TB] FAIL status_ovf_clear: got %h want %h", got, expStatus()); end
        bus_write(3'd1, 16'h8000);
        bus_read(3'd1, got);
        total++;
        if (got !== expStatus()) begin bad++; $display("[TB] FAIL status_after_flush: got %h want %h", got, expStatus()); end
    endtask

    task automatic test_irq();
        logic [15:0] got, expd;
        bus_write(3'd3, 16'h0004);
        for (int i = 0; i < 3; i++) push_word(16'h2000 + 16'(i));
        total++;
        if (irq !== expIrq()) begin bad++; $display("[TB] FAIL irq_below_thresh: got %b want %b", irq, expIrq()); end
        push_word(16'h2003);
        total++;
        if (irq !== expIrq()) begin bad++; $display("[TB] FAIL irq_at_thresh: got %b want %b", irq, expIrq()); end
        modelPop(expd);
        bus_read(3'd0, got);
        total++;
        if (got !== expd) begin bad++; $display("[TB] FAIL irq_pop_data: got %h want %h", got, expd); end
        total++;
        if (irq !== expIrq()) begin bad++; $display("[TB] FAIL irq_after_pop: got %b want %b", irq, expIrq()); end
        bus_write(3'd1, 16'h8000);
        bus_write(3'd3, 16'h0000);
        for (int i = 0; i < DEPTH; i++) push_word(16'h2100 + 16'(i));
        total++;
        if (irq !== expIrq()) begin bad++; $display("[TB] FAIL irq_thresh_zero: got %b want %b", irq, expIrq()); end
        bus_write(3'd3, 16'(DEPTH));
        total++;
        if (irq !== expIrq()) begin bad++; $display("[TB] FAIL irq_thresh_depth: got %b want %b", irq, expIrq()); end
        bus_write(3'd3, 16'(DEPTH + 1));
        total++;
        if (irq !== expIrq()) begin bad++; $display("[TB] FAIL irq_thresh_over_depth: got %b want %b", irq, expIrq()); end
        bus_write(3'd3, 16'hFFFF);
        bus_read(3'd3, got);
        total++;
        if (got !== 16'(mThresh)) begin bad++; $display("[TB] FAIL thresh_truncate: got %h want %h", got, 16'(mThresh)); end
    endtask

    task automatic test_push_pop_full();
        logic [15:0] got, expd;
        expd = sb[0];
        bus_if.src_valid = 1'b1; bus_if.src_data = 16'hA5A5;
        bus_if.cs = 1'b1; bus_if.rd_stb = 1'b1; bus_if.reg_addr = 3'd0;
        cycle();
        begin logic [15:0] dummy; modelPush(16'hA5A5); modelPop(dummy); end
        total++;
        if (bus_if.rdata !== expd) begin bad++; $display("[TB] FAIL full_pop_data: got %h want %h", bus_if.rdata, expd); end
        bus_if.reg_addr = 3'd2;
        cycle();
        bus_if.cs = 1'b0; bus_if.rd_stb = 1'b0; bus_if.src_valid = 1'b0;
        total++;
        if (bus_if.rdata !== 16'(mCount)) begin bad++; $display("[TB] FAIL count_after_rejected_push: got %h want %h", bus_if.rdata, 16'(mCount)); end
        modelPush(16'hA5A5);
        bus_read(3'd2, got);
        total++;
        if (got !== 16'(mCount)) begin bad++; $display("[TB] FAIL count_after_retry_push: got %h want %h", got, 16'(mCount)); end
        bus_read(3'd1, got);
        total++;
        if (got !== expStatus()) begin bad++; $display("[TB] FAIL status_after_retry_push: got %h want %h", got, expStatus()); end
    endtask

    task automatic test_flush();
        logic [15:0] got, preStatus;
        bus_if.cs = 1'b1; bus_if.wr_stb = 1'b1; bus_if.reg_addr = 3'd1; bus_if.wdata = 16'h8000;
        bus_if.src_valid = 1'b1; bus_if.src_data = 16'h7777;
        cycle();
        bus_if.cs = 1'b0; bus_if.wr_stb = 1'b0; bus_if.src_valid = 1'b0;
        sb.delete(); mCount = 0;
        bus_read(3'd1, got);
        total++;
        if (got !== expStatus()) begin bad++; $display("[TB] FAIL flush_keeps_ovf: got %h want %h", got, expStatus()); end
        bus_write(3'd1, 16'h0004);
        for (int i = 0; i < DEPTH; i++) push_word(16'h5000 + 16'(i));
        preStatus = expStatus();
        bus_if.cs = 1'b1; bus_if.wr_stb = 1'b1; bus_if.rd_stb = 1'b1;
        bus_if.reg_addr = 3'd1; bus_if.wdata = 16'h8000;
        bus_if.src_valid = 1'b1; bus_if.src_data = 16'h7778;
        cycle();
        bus_if.cs = 1'b0; bus_if.wr_stb = 1'b0; bus_if.rd_stb = 1'b0; bus_if.src_valid = 1'b0;
        sb.delete(); mCount = 0;
        total++;
        if (bus_if.rdata !== preStatus) begin bad++; $display("[TB] FAIL flush_same_cycle_read: got %h want %h", bus_if.rdata, preStatus); end
        bus_read(3'd1, got);
        total++;
        if (got !== expStatus()) begin bad++; $display("[TB] FAIL flush_push_no_ovf: got %h want %h", got, expStatus()); end
        bus_read(3'd2, got);
        total++;
        if (got !== 16'(mCount)) begin bad++; $display("[TB] FAIL count_after_flush: got %h want %h", got, 16'(mCount)); end
    endtask

    task automatic test_async_reset();
        logic [15:0] got, expd;
        bus_write(3'd3, 16'h0002);
        for (int i = 0; i < DEPTH; i++) push_word(16'h3000 + 16'(i));
        modelPop(expd);
        bus_read(3'd0, got);
        total++;
        if (got !== expd) begin bad++; $display("[TB] FAIL pre_reset_pop: got %h want %h", got, expd); end
        bus_if.src_valid = 1'b1; bus_if.src_data = 16'h4444;
        cycle();
        #3;
        reset_n = 1'b0;
        #1;
        modelReset();
        total++;
        if (bus_if.rdata !== 16'h0000) begin bad++; $display("[TB] FAIL async_reset_rdata: got %h want 0000", bus_if.rdata); end
        total++;
        if (irq !== 1'b0) begin bad++; $display("[TB] FAIL async_reset_irq: got %b want 0", irq); end
        total++;
        if (bus_if.src_ready !== 1'b1) begin bad++; $display("[TB] FAIL async_reset_src_ready: got %b want 1", bus_if.src_ready); end
        bus_if.src_valid = 1'b0;
        cycle();
        reset_n = 1'b1;
        cycle();
        bus_read(3'd2, got);
        total++;
        if (got !== 16'h0000) begin bad++; $display("[TB] FAIL count_after_async_reset: got %h want 0000", got); end
        bus_read(3'd3, got);
        total++;
        if (got !== 16'h0008) begin bad++; $display("[TB] FAIL thresh_after_async_reset: got %h want 0008", got); end
        bus_read(3'd1, got);
        total++;
        if (got !== expStatus()) begin bad++; $display("[TB] FAIL status_after_async_reset: got %h want %h", got, expStatus()); end
    endtask

    initial begin
        test_reset();
        test_fifo_order();
        test_full_ovf();
        test_irq();
        test_push_pop_full();
        test_flush();
        test_async_reset();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #500000;
        $display("[TB] FAIL watchdog: got timeout want completion");
        $fatal(1, "[TB] watchdog expired");
    end

endmodule
